// File: rtl/avb_audio_pkg.sv
// Shared definitions for the AVB audio transmit path.
//   DATA_W_DEF / SLOT_W_DEF : default sample width and slot width (BCLKs per channel)
//   stereo_frame_t          : one stereo frame, left sample in the upper half
//   i2s_state_e             : serializer FSM state (IDLE / RUN)
package avb_audio_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int SLOT_W_DEF = 32;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] left;
        logic [DATA_W_DEF-1:0] right;
    } stereo_frame_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } i2s_state_e;

endpackage

// File: rtl/avb_i2s_fifo.sv
// Synchronous frame FIFO with a show-ahead read port.
//   clk, reset : clock and synchronous active-high reset (empties the FIFO)
//   push/wr_data : write one entry; ignored when full
//   pop/rd_data  : rd_data always shows the oldest entry; pop discards it; ignored when empty
//   full, empty  : occupancy flags
module avb_i2s_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    import avb_audio_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/avb_i2s_tx.sv
// I2S master transmitter: buffers stereo frames and serializes them MSB first.
//   clk_clk, reset_reset : master clock, synchronous active-high reset
//   snk_data/valid/ready : frame input {left, right}
//   enable               : run the serializer; low returns to idle at once
//   clear_underflow      : pulse that clears the sticky underflow flag
//   i2s_bclk/lrclk/sdata : I2S bus (lrclk 0 = left, leads data by one BCLK)
//   underflow            : sticky, a frame boundary found the FIFO empty
//   frame_tick           : one-cycle pulse on each frame load
//   state                : current FSM state (observability)
//
// Handshake: a frame transfers on any cycle with snk_valid && snk_ready.
// snk_ready is !full (and low during reset); it does not look at a
// same-cycle pop, and valid may be held while ready is low.
module avb_i2s_tx
    import avb_audio_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SLOT_W     = SLOT_W_DEF,
    parameter int BCLK_DIV   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [2*DATA_W-1:0] snk_data,
    input  logic                snk_valid,
    output logic                snk_ready,
    input  logic                enable,
    input  logic                clear_underflow,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic                underflow,
    output logic                frame_tick,
    output i2s_state_e          state
);

    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int PW         = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(FRAME_BITS - 1);

    i2s_state_e state_next;
    logic       run;

    logic [DIV_W-1:0]      div;
    logic                  bclk;
    logic                  lrclk;
    logic [PW-1:0]         p;
    logic [FRAME_BITS-1:0] sr;

    logic          div_wrap;
    logic          fall;
    logic          wrap;
    logic [PW-1:0] p_next;
    logic [PW-1:0] p_after;
    logic          lr_next;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [2*DATA_W-1:0]   fifo_rd;
    logic [SLOT_W-1:0]     left_slot;
    logic [SLOT_W-1:0]     right_slot;

    assign snk_ready = !fifo_full && !reset_reset;
    assign fifo_push = snk_valid && snk_ready;
    assign fifo_pop  = wrap && !fifo_empty;

    avb_i2s_fifo #(
        .W     (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_clk),
        .reset   (reset_reset),
        .push    (fifo_push),
        .wr_data (snk_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Samples are left-justified in their slot; the tail is zero padding.
    assign left_slot  = SLOT_W'(fifo_rd[2*DATA_W-1 -: DATA_W]) << (SLOT_W - DATA_W);
    assign right_slot = SLOT_W'(fifo_rd[DATA_W-1:0]) << (SLOT_W - DATA_W);

    // FSM: state register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (enable)  state_next = ST_RUN;
            ST_RUN:  if (!enable) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs. Dropping enable idles the datapath in the same cycle,
    // so the bus is quiet on the very next cycle.
    always_comb begin
        run = 1'b0;
        case (state)
            ST_RUN:  run = enable;
            default: run = 1'b0;
        endcase
    end

    always_comb begin
        div_wrap = run && (div == DIV_W'(BCLK_DIV - 1));
        fall     = div_wrap && bclk;
        wrap     = fall && (p == P_LAST);
        p_next   = (p == P_LAST) ? '0 : p + 1'b1;
        // lrclk reflects the slot of the *next* bit: the one-BCLK I2S lead.
        p_after  = (p_next == P_LAST) ? '0 : p_next + 1'b1;
        lr_next  = (p_after >= PW'(SLOT_W));
    end

    // Idle (and reset) hold p at the last position so the first falling
    // edge after enable wraps to 0 and loads a frame.
    always_ff @(posedge clk_clk) begin
        if (reset_reset || !run) begin
            div   <= '0;
            bclk  <= 1'b0;
            lrclk <= 1'b0;
            p     <= P_LAST;
            sr    <= '0;
        end else begin
            div <= div_wrap ? '0 : div + 1'b1;
            if (div_wrap) begin
                bclk <= !bclk;
            end
            if (fall) begin
                p     <= p_next;
                lrclk <= lr_next;
                if (wrap) begin
                    sr <= fifo_empty ? '0 : {left_slot, right_slot};
                end else begin
                    sr <= sr << 1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            frame_tick <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            frame_tick <= wrap;
            if (wrap && fifo_empty) begin
                underflow <= 1'b1;
            end else if (clear_underflow) begin
                underflow <= 1'b0;
            end
        end
    end

    assign i2s_bclk  = bclk;
    assign i2s_lrclk = lrclk;
    assign i2s_sdata = sr[FRAME_BITS-1];

endmodule

// File: tb/tb_avb_i2s_tx.sv
module tb_avb_i2s_tx;
  import avb_audio_pkg::*;

  localparam int DW    = DATA_W_DEF;
  localparam int SLOT  = SLOT_W_DEF;
  localparam int BDIV  = 2;
  localparam int DEPTH = 4;
  localparam int FBITS = 2 * SLOT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (default parameters) ----------------
  logic [2*DW-1:0] snk_data = '0;
  logic            snk_valid = 1'b0;
  logic            snk_ready;
  logic            en = 1'b0;
  logic            clr = 1'b0;
  logic            i2s_bclk, i2s_lrclk, i2s_sdata, underflow, frame_tick;
  i2s_state_e      dut_state;

  avb_i2s_tx #(.DATA_W(DW), .SLOT_W(SLOT), .BCLK_DIV(BDIV), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk_clk         (clk),
    .reset_reset     (rst),
    .snk_data        (snk_data),
    .snk_valid       (snk_valid),
    .snk_ready       (snk_ready),
    .enable          (en),
    .clear_underflow (clr),
    .i2s_bclk        (i2s_bclk),
    .i2s_lrclk       (i2s_lrclk),
    .i2s_sdata       (i2s_sdata),
    .underflow       (underflow),
    .frame_tick      (frame_tick),
    .state           (dut_state)
  );

  // ---------------- DUT2 (fast, unpadded slots) ----------------
  logic [47:0] data2 = '0;
  logic        valid2 = 1'b0;
  logic        ready2;
  logic        en2 = 1'b0;
  logic        clr2 = 1'b0;
  logic        bclk2, lrclk2, sd2, uf2, tick2;
  i2s_state_e  state2;

  avb_i2s_tx #(.DATA_W(24), .SLOT_W(24), .BCLK_DIV(1), .FIFO_DEPTH(4)) u_dut2 (
    .clk_clk         (clk),
    .reset_reset     (rst),
    .snk_data        (data2),
    .snk_valid       (valid2),
    .snk_ready       (ready2),
    .enable          (en2),
    .clear_underflow (clr2),
    .i2s_bclk        (bclk2),
    .i2s_lrclk       (lrclk2),
    .i2s_sdata       (sd2),
    .underflow       (uf2),
    .frame_tick      (tick2),
    .state           (state2)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input stereo_frame_t f, input int p);
    int h;
    int k;
    h = p / SLOT;
    k = p % SLOT;
    if (k >= DW) return 1'b0;
    return (h == 0) ? f.left[DW-1-k] : f.right[DW-1-k];
  endfunction

  // ---------------- scoreboard / reference model ----------------
  logic [2*DW-1:0] exp_q[$];
  stereo_frame_t   m_cur = '0;
  bit              m_state = 0;
  int              m_div = 0;
  bit              m_bclk = 0;
  int              m_p = FBITS - 1;
  bit              m_sd = 0;
  bit              m_lr = 0;
  bit              m_uf = 0;
  bit              m_tick = 0;
  int              m_tick_cnt = 0;
  int              frames_done = 0;
  logic [63:0]     cap = '0;
  logic [63:0]     lrw = '0;
  logic [63:0]     last_word = '0;
  logic [63:0]     last_lr = '0;

  // Inputs as seen just before the next rising edge.
  bit              pv_rst = 1;
  bit              pv_en = 0;
  bit              pv_clr = 0;
  bit              pv_acc = 0;
  logic [2*DW-1:0] pv_data = '0;

  always @(negedge clk) begin : mon
    bit ev;
    bit fell;
    ev = 0;
    fell = 0;
    m_tick = 0;
    if (pv_rst) begin
      exp_q.delete();
      m_state = 0; m_div = 0; m_bclk = 0; m_p = FBITS - 1;
      m_sd = 0; m_lr = 0; m_uf = 0;
    end else begin
      if (m_state && pv_en) begin
        if (m_div == BDIV - 1) begin
          m_div = 0;
          if (m_bclk) begin
            fell = 1;
            m_p = (m_p + 1) % FBITS;
            if (m_p == 0) begin
              m_tick = 1;
              m_tick_cnt++;
              if (exp_q.size() > 0) m_cur = exp_q.pop_front();
              else begin
                m_cur = '0;
                ev = 1;
              end
            end
            m_sd = exp_bit(m_cur, m_p);
            m_lr = (((m_p + 1) % FBITS) >= SLOT);
          end
          m_bclk = !m_bclk;
        end else begin
          m_div++;
        end
      end else begin
        m_div = 0; m_bclk = 0; m_p = FBITS - 1; m_sd = 0; m_lr = 0;
        m_state = pv_en;
      end
      if (pv_acc) exp_q.push_back(pv_data);
      if (ev) m_uf = 1;
      else if (pv_clr) m_uf = 0;
    end

    check("bclk", i2s_bclk, m_bclk);
    check("lrclk", i2s_lrclk, m_lr);
    check("sdata", i2s_sdata, m_sd);
    check("frame_tick", frame_tick, m_tick);
    check("underflow", underflow, m_uf);
    check("snk_ready", snk_ready, (!rst && exp_q.size() < DEPTH));
    check("state", dut_state, m_state);

    if (fell) begin
      if (m_p == 0) begin
        cap = '0;
        lrw = '0;
      end
      cap = {cap[62:0], i2s_sdata};
      lrw = {lrw[62:0], i2s_lrclk};
      if (m_p == FBITS - 1) begin
        last_word = cap;
        last_lr = lrw;
        frames_done++;
      end
    end

    pv_rst  = rst;
    pv_en   = en;
    pv_clr  = clr;
    pv_acc  = snk_valid && snk_ready;
    pv_data = snk_data;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [47:0] rand_frame();
    return {24'($urandom_range(0, 32'h00FF_FFFF)), 24'($urandom_range(0, 32'h00FF_FFFF))};
  endfunction

  task automatic push_frame(input logic [47:0] f);
    bit acc;
    int g;
    snk_valid = 1'b1;
    snk_data = f;
    g = 0;
    do begin
      acc = snk_ready;
      step(1);
      g++;
    end while (!acc && g < 600);
    snk_valid = 1'b0;
    check("push_timeout", acc, 1'b1);
  endtask

  task automatic wait_ticks(input int n, input string tag);
    int t0;
    int g;
    t0 = m_tick_cnt;
    g = 0;
    while ((m_tick_cnt - t0) < n && g < n * 300 + 50) begin
      step(1);
      g++;
    end
    check(tag, ((m_tick_cnt - t0) >= n), 1'b1);
  endtask

  task automatic wait_p(input int target, input string tag);
    int g;
    g = 0;
    while (m_p != target && g < 400) begin
      step(1);
      g++;
    end
    check(tag, (m_p == target), 1'b1);
  endtask

  int n_acc = 0;

  task automatic stream_step();
    bit a;
    a = snk_ready;
    step(1);
    if (a) begin
      n_acc++;
      snk_data = rand_frame();
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    int g;
    int t0;
    int fd0;
    int tog_err;
    int nb;
    bit pb;
    logic [47:0] cap2;
    logic [47:0] f2;

    // Reset: ready low while reset is held, high right after.
    step(3);
    check("rst_ready_low", snk_ready, 1'b0);
    check("rst_underflow", underflow, 1'b0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", snk_ready, 1'b1);
    step(2);

    // Known frame: first fall 4 cycles into RUN, slot layout and lrclk lead.
    push_frame({24'hABCDEF, 24'h123456});
    en = 1'b1;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!frame_tick && n < 20);
    check("first_tick_latency", n, 5);
    fd0 = frames_done;
    g = 0;
    while (frames_done == fd0 && g < 400) begin
      step(1);
      g++;
    end
    check("frame0_bits", last_word, 64'hABCDEF00_12345600);
    check("frame0_lrclk", last_lr, 64'h00000001_FFFFFFFE);
    check("uf_before_empty", underflow, 1'b0);

    // Empty FIFO at the next boundary: zeros and sticky underflow.
    wait_ticks(1, "uf_tick_wait");
    check("uf_set", underflow, 1'b1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("uf_cleared", underflow, 1'b0);
    // Clear landing on an underflowing boundary: set wins.
    g = 0;
    while (!(m_p == FBITS - 1 && m_bclk && m_div == 0) && g < 400) begin
      step(1);
      g++;
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_on_wrap_tick", frame_tick, 1'b1);
    check("set_beats_clear", underflow, 1'b1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;

    // Back-pressure: 4 accepts while idle, then one per frame while running.
    en = 1'b0;
    step(1);
    n_acc = 0;
    snk_data = rand_frame();
    snk_valid = 1'b1;
    for (int i = 0; i < 8; i++) stream_step();
    check("fill_accepts", n_acc, 4);
    check("full_not_ready", snk_ready, 1'b0);
    en = 1'b1;
    t0 = m_tick_cnt;
    g = 0;
    while ((m_tick_cnt - t0) < 5 && g < 1600) begin
      stream_step();
      g++;
    end
    for (int i = 0; i < 3; i++) stream_step();
    snk_valid = 1'b0;
    check("stream_accepts", n_acc, 4 + (m_tick_cnt - t0));

    // Drop enable mid-frame: bus idles next cycle, FIFO untouched.
    wait_p(40, "wait_p40");
    en = 1'b0;
    step(1);
    check("stop_bclk", i2s_bclk, 1'b0);
    check("stop_sdata", i2s_sdata, 1'b0);
    check("stop_lrclk", i2s_lrclk, 1'b0);
    check("stop_fifo_kept", snk_ready, 1'b0);
    step(5);
    en = 1'b1;
    wait_ticks(1, "resume_tick");

    // Reset mid-frame with 3 frames queued.
    wait_p(20, "wait_p20");
    rst = 1'b1;
    #1;
    check("midrst_ready_low", snk_ready, 1'b0);
    step(2);
    rst = 1'b0;
    #1;
    check("post_rst_ready", snk_ready, 1'b1);
    check("post_rst_uf", underflow, 1'b0);
    wait_ticks(1, "post_rst_tick");
    check("post_rst_underflow", underflow, 1'b1);
    en = 1'b0;
    step(2);

    // DUT2: BCLK_DIV=1, SLOT_W=DATA_W=24.
    f2 = rand_frame();
    data2 = f2;
    valid2 = 1'b1;
    check("dut2_ready", ready2, 1'b1);
    step(1);
    valid2 = 1'b0;
    en2 = 1'b1;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!tick2 && n < 20);
    check("dut2_first_tick", n, 3);
    cap2 = {47'b0, sd2};
    nb = 1;
    pb = bclk2;
    tog_err = 0;
    n = 0;
    do begin
      step(1);
      n++;
      if (bclk2 == pb) tog_err++;
      if (pb && !bclk2 && nb < 48) begin
        cap2 = {cap2[46:0], sd2};
        nb++;
      end
      pb = bclk2;
    end while (!tick2 && n < 200);
    check("dut2_frame_len", n, 96);
    check("dut2_bclk_period", tog_err, 0);
    check("dut2_data", cap2, f2);
    en2 = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
